// File: rtl/store_buf_pkg.sv
// rtl/store_buf_pkg.sv - shared constants and entry type for the store buffer
// Contents: default geometry (SB_DEPTH, SB_PTR_W, SB_ADDR_W, SB_DATA_W) and
// sb_entry_t {valid, addr, data}, the per-slot FIFO record.
package store_buf_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_PTR_W  = $clog2(SB_DEPTH);
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buf_match.sv
// rtl/store_buf_match.sv - load forwarding / partial-overlap comparator array
// Ports:
//   ld_valid_i, ld_addr_i  : load presented in MEM stage
//   ent_i[DEPTH]           : buffered entries (registered state)
//   head_i                 : index of the oldest entry
//   ld_hit_o, ld_data_o    : exact match, data of the youngest matching entry
//   ld_conflict_o          : a valid entry overlaps the load's word without matching it
module store_buf_match
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  sb_entry_t         ent_i [DEPTH],
    input  logic [PTR_W-1:0]  head_i,
    output logic              ld_hit_o,
    output logic [DATA_W-1:0] ld_data_o,
    output logic              ld_conflict_o
);

    logic              hit_any;
    logic              conf_any;
    logic [DATA_W-1:0] data_sel;
    logic [PTR_W-1:0]  idx;
    logic [ADDR_W-1:0] diff_up;
    logic [ADDR_W-1:0] diff_dn;

    // Walk oldest -> youngest starting at head; a later match overwrites
    // data_sel, so the youngest matching store is the one forwarded.
    always_comb begin
        hit_any  = 1'b0;
        conf_any = 1'b0;
        data_sel = '0;
        idx      = '0;
        diff_up  = '0;
        diff_dn  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx     = head_i + PTR_W'(i);
            diff_up = ent_i[idx].addr - ld_addr_i;
            diff_dn = ld_addr_i - ent_i[idx].addr;
            if (ent_i[idx].valid) begin
                if (ent_i[idx].addr == ld_addr_i) begin
                    hit_any  = 1'b1;
                    data_sel = ent_i[idx].data;
                end else if ((diff_up <= ADDR_W'(3)) || (diff_dn <= ADDR_W'(3))) begin
                    // diff is non-zero here, so <= 3 means |diff| in 1..3 (mod 2^ADDR_W)
                    conf_any = 1'b1;
                end
            end
        end
    end

    // A partial overlap anywhere suppresses forwarding: the load must stall.
    assign ld_conflict_o = ld_valid_i && conf_any;
    assign ld_hit_o      = ld_valid_i && hit_any && !conf_any;
    assign ld_data_o     = ld_hit_o ? data_sel : '0;

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - word store buffer between MEM stage and data memory write port
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   st_valid/st_addr/st_data       : store from pipeline; st_ready = !full
//   ld_valid/ld_addr               : load probe; ld_hit/ld_data/ld_conflict results
//   dm_busy                        : DM read port in use, blocks draining
//   MemWrite/MemAddr/MemWriteData  : DM write port, driven from the head entry
//   empty, full                    : occupancy flags
// Optional feature: STORE_BUF_COALESCE_EN merges a store into the youngest
// entry when the address matches exactly.
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_conflict,
    input  logic              dm_busy,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    sb_entry_t        ent_q [DEPTH];
    sb_entry_t        ent_d [DEPTH];

    logic pop;
    logic push;
    logic merge;
    logic alloc;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign st_ready = !full;            // no path from dm_busy by design
    assign pop      = !empty && !dm_busy;
    assign push     = st_valid && st_ready;

`ifdef STORE_BUF_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest = tail_q - 1'b1;
    // Never merge into the head while it is being drained: DM already
    // samples its old data this cycle, so the new store must allocate.
    assign merge = push && !empty && ent_q[youngest].valid
                && (ent_q[youngest].addr == st_addr)
                && !(pop && (youngest == head_q));
`else
    assign merge = 1'b0;
`endif

    assign alloc = push && !merge;

    // DM write port: purely from registered state plus dm_busy, so it holds
    // steady across the cycle for DM's negedge write.
    assign MemWrite     = pop;
    assign MemAddr      = pop ? ent_q[head_q].addr : '0;
    assign MemWriteData = pop ? ent_q[head_q].data : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
        end
        if (pop) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = head_q + 1'b1;
        end
        if (alloc) begin
            ent_d[tail_q] = '{valid: 1'b1, addr: st_addr, data: st_data};
            tail_d        = tail_q + 1'b1;
        end
`ifdef STORE_BUF_COALESCE_EN
        if (merge) begin
            ent_d[youngest].data = st_data;
        end
`endif
        if (alloc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!alloc && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    store_buf_match #(
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match (
        .ld_valid_i    (ld_valid),
        .ld_addr_i     (ld_addr),
        .ent_i         (ent_q),
        .head_i        (head_q),
        .ld_hit_o      (ld_hit),
        .ld_data_o     (ld_data),
        .ld_conflict_o (ld_conflict)
    );

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed table-driven bench for store_buffer
module tb_store_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_conflict;
    logic        dm_busy;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWriteData;
    logic        empty;
    logic        full;

    int tests;
    int fails;

    store_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_ready     (st_ready),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .ld_data      (ld_data),
        .ld_conflict  (ld_conflict),
        .dm_busy      (dm_busy),
        .MemWrite     (MemWrite),
        .MemAddr      (MemAddr),
        .MemWriteData (MemWriteData),
        .empty        (empty),
        .full         (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stv;
        logic [31:0] sta;
        logic [31:0] std;
        logic        ldv;
        logic [31:0] lda;
        logic        busy;
        logic        e_rdy;
        logic        e_emp;
        logic        e_full;
        logic        e_mw;
        logic [31:0] e_ma;
        logic [31:0] e_md;
        logic        e_hit;
        logic [31:0] e_ldd;
        logic        e_conf;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(logic stv, logic [31:0] sta, logic [31:0] std,
                                logic ldv, logic [31:0] lda, logic busy,
                                logic rdy, logic emp, logic fl, logic mw,
                                logic [31:0] ma, logic [31:0] md,
                                logic hit, logic [31:0] ldd, logic conf);
        vec_t v;
        v.stv = stv; v.sta = sta; v.std = std; v.ldv = ldv; v.lda = lda; v.busy = busy;
        v.e_rdy = rdy; v.e_emp = emp; v.e_full = fl; v.e_mw = mw; v.e_ma = ma;
        v.e_md = md; v.e_hit = hit; v.e_ldd = ldd; v.e_conf = conf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        chk({tag, " st_ready"},     32'(st_ready),    32'(v.e_rdy));
        chk({tag, " empty"},        32'(empty),       32'(v.e_emp));
        chk({tag, " full"},         32'(full),        32'(v.e_full));
        chk({tag, " MemWrite"},     32'(MemWrite),    32'(v.e_mw));
        chk({tag, " MemAddr"},      MemAddr,          v.e_ma);
        chk({tag, " MemWriteData"}, MemWriteData,     v.e_md);
        chk({tag, " ld_hit"},       32'(ld_hit),      32'(v.e_hit));
        chk({tag, " ld_data"},      ld_data,          v.e_ldd);
        chk({tag, " ld_conflict"},  32'(ld_conflict), 32'(v.e_conf));
    endtask

    task automatic drive(input vec_t v);
        st_valid = v.stv; st_addr = v.sta; st_data = v.std;
        ld_valid = v.ldv; ld_addr = v.lda; dm_busy = v.busy;
    endtask

    logic [31:0] exp_head_data;
    logic        exp_full_after;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; dm_busy = 1'b0;

        //            stv sta    std           ldv lda    bsy rdy emp ful mw ma     md            hit ldd           cf
        vecs[0]  = mk(1, 32'h10, 32'hDEADBEEF, 0, 32'h0,  0,  1,  1,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[1]  = mk(0, 32'h0,  32'h0,        0, 32'h0,  0,  1,  0,  0,  1, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0);
        vecs[2]  = mk(0, 32'h0,  32'h0,        0, 32'h0,  1,  1,  1,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[3]  = mk(1, 32'h00, 32'hA0,       0, 32'h0,  1,  1,  1,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[4]  = mk(1, 32'h04, 32'hA1,       0, 32'h0,  1,  1,  0,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[5]  = mk(1, 32'h08, 32'hA2,       0, 32'h0,  1,  1,  0,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[6]  = mk(1, 32'h0C, 32'hA3,       0, 32'h0,  1,  1,  0,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[7]  = mk(1, 32'h40, 32'hBAD,      1, 32'h08, 1,  0,  0,  1,  0, 32'h0,  32'h0,        1, 32'hA2,       0);
        vecs[8]  = mk(1, 32'h40, 32'hBAD,      1, 32'h00, 0,  0,  0,  1,  1, 32'h00, 32'hA0,       1, 32'hA0,       0);
        vecs[9]  = mk(1, 32'h40, 32'hBAD,      0, 32'h0,  0,  1,  0,  0,  1, 32'h04, 32'hA1,       0, 32'h0,        0);
        vecs[10] = mk(0, 32'h0,  32'h0,        0, 32'h0,  0,  1,  0,  0,  1, 32'h08, 32'hA2,       0, 32'h0,        0);
        vecs[11] = mk(0, 32'h0,  32'h0,        0, 32'h0,  0,  1,  0,  0,  1, 32'h0C, 32'hA3,       0, 32'h0,        0);
        vecs[12] = mk(0, 32'h0,  32'h0,        1, 32'h40, 0,  1,  0,  0,  1, 32'h40, 32'hBAD,      1, 32'hBAD,      0);
        vecs[13] = mk(0, 32'h0,  32'h0,        0, 32'h0,  0,  1,  1,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[14] = mk(1, 32'h20, 32'h11111111, 0, 32'h0,  1,  1,  1,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[15] = mk(1, 32'h20, 32'h22222222, 1, 32'h20, 1,  1,  0,  0,  0, 32'h0,  32'h0,        1, 32'h11111111, 0);
        vecs[16] = mk(0, 32'h0,  32'h0,        1, 32'h20, 1,  1,  0,  0,  0, 32'h0,  32'h0,        1, 32'h22222222, 0);
        vecs[17] = mk(0, 32'h0,  32'h0,        1, 32'h22, 1,  1,  0,  0,  0, 32'h0,  32'h0,        0, 32'h0,        1);
        vecs[18] = mk(0, 32'h0,  32'h0,        1, 32'h24, 1,  1,  0,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[19] = mk(0, 32'h0,  32'h0,        1, 32'h1E, 1,  1,  0,  0,  0, 32'h0,  32'h0,        0, 32'h0,        1);
        vecs[20] = mk(1, 32'h23, 32'h33333333, 0, 32'h20, 1,  1,  0,  0,  0, 32'h0,  32'h0,        0, 32'h0,        0);
        vecs[21] = mk(0, 32'h0,  32'h0,        1, 32'h20, 1,  1,  0,  0,  0, 32'h0,  32'h0,        0, 32'h0,        1);

        // Reset state, checked while rst_n is still low
        #2;
        check_vec("reset", mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            check_vec($sformatf("v%0d", i), vecs[i]);
            @(negedge clk);
        end

        // Drain starts, then async reset mid-cycle discards everything
`ifdef STORE_BUF_COALESCE_EN
        exp_head_data = 32'h22222222;
`else
        exp_head_data = 32'h11111111;
`endif
        st_valid = 1'b0; dm_busy = 1'b0; ld_valid = 1'b1; ld_addr = 32'h20;
        #1;
        chk("pre_rst MemWrite",     32'(MemWrite), 32'h1);
        chk("pre_rst MemAddr",      MemAddr,       32'h20);
        chk("pre_rst MemWriteData", MemWriteData,  exp_head_data);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst MemWrite",     32'(MemWrite),    32'h0);
        chk("rst empty",        32'(empty),       32'h1);
        chk("rst st_ready",     32'(st_ready),    32'h1);
        chk("rst MemAddr",      MemAddr,          32'h0);
        chk("rst MemWriteData", MemWriteData,     32'h0);
        chk("rst ld_hit",       32'(ld_hit),      32'h0);
        chk("rst ld_conflict",  32'(ld_conflict), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst MemWrite", 32'(MemWrite), 32'h0);
        chk("post_rst empty",    32'(empty),    32'h1);
        @(negedge clk);
        chk("post_rst2 MemWrite", 32'(MemWrite), 32'h0);

        // Repeated store to the youngest address: merged or allocated
        ld_valid = 1'b0; dm_busy = 1'b1; st_valid = 1'b1;
        st_addr = 32'h30; st_data = 32'h1; @(negedge clk);
        st_addr = 32'h30; st_data = 32'h2; @(negedge clk);
        st_addr = 32'h34; st_data = 32'h3; @(negedge clk);
        st_addr = 32'h38; st_data = 32'h4; @(negedge clk);
        st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h30;
        #1;
`ifdef STORE_BUF_COALESCE_EN
        exp_full_after = 1'b0;
`else
        exp_full_after = 1'b1;
`endif
        chk("repeat full",     32'(full),     32'(exp_full_after));
        chk("repeat st_ready", 32'(st_ready), 32'(!exp_full_after));
        chk("repeat ld_data",  ld_data,       32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
